// File: rtl/scan_pkg.sv
// Shared types for the LED scan matrix: FSM state encoding and point-index sizing.
// Optional build macro used by the matrix files: SCAN_PWM_EN.
package scan_pkg;

  typedef enum logic [1:0] {
    S_LATCH = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2,
    S_SKIP  = 2'd3
  } scan_state_e;

  // Width of the point index; a single-point matrix still needs one bit.
  function automatic int idx_width(input int n_points);
    return (n_points > 1) ? $clog2(n_points) : 1;
  endfunction

endpackage

// File: rtl/scan_matrix_if.sv
// Point-enable inputs and one-hot row/column drive of the scan matrix.
// SCAN_PWM_EN adds the 4-bit brightness input.
interface scan_matrix_if #(
  parameter int ROWS = 5,
  parameter int COLS = 7
);

  logic [ROWS*COLS-1:0] ens;
  logic                 skip_dark;
`ifdef SCAN_PWM_EN
  logic [3:0]           bright;
`endif
  logic [ROWS-1:0]      row;
  logic [COLS-1:0]      column;
  logic                 frame_start;

`ifdef SCAN_PWM_EN
  modport master (output ens, output skip_dark, output bright,
                  input row, input column, input frame_start);
  modport slave  (input ens, input skip_dark, input bright,
                  output row, output column, output frame_start);
`else
  modport master (output ens, output skip_dark,
                  input row, input column, input frame_start);
  modport slave  (input ens, input skip_dark,
                  output row, output column, output frame_start);
`endif

endinterface

// File: rtl/scan_point_decode.sv
// Maps a linear point index to one-hot row/column drive; all zeros when not on.
// Purely combinational.
module scan_point_decode
  import scan_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 7,
  parameter int IW   = idx_width(ROWS * COLS)
) (
  input  logic [IW-1:0]   i_idx,
  input  logic            i_on,
  output logic [ROWS-1:0] o_row,
  output logic [COLS-1:0] o_column
);

  always_comb begin
    o_row    = '0;
    o_column = '0;
    if (i_on) begin
      for (int r = 0; r < ROWS; r++) begin
        if ((int'(i_idx) / COLS) == r) o_row[r] = 1'b1;
      end
      for (int c = 0; c < COLS; c++) begin
        if ((int'(i_idx) % COLS) == c) o_column[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_matrix.sv
// Time-multiplexed point scanner: latches enables per frame, dwells on each point, then blanks.
// Outputs are registered one cycle behind the FSM state; SCAN_PWM_EN adds brightness gating.
module scan_matrix
  import scan_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 7,
  parameter int DWELL = 16384,
  parameter int BLANK = 64
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  scan_matrix_if.slave bus
);

  localparam int NPTS = ROWS * COLS;
  localparam int IW   = idx_width(NPTS);
  localparam int DW   = $clog2(DWELL + 1);
  localparam int BW   = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NPTS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_e     r_state;
  scan_state_e     w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [IW-1:0]   w_idx_inc;
  logic [DW-1:0]   r_dwell_cnt;
  logic [DW-1:0]   w_dwell_nxt;
  logic [BW-1:0]   r_blank_cnt;
  logic [BW-1:0]   w_blank_nxt;
  logic [NPTS-1:0] r_shadow;
  logic            r_skip_q;
  logic            w_latch;
  logic            w_point_done;
  logic            w_pwm_ok;
  logic            w_on;
  logic [ROWS-1:0] w_row;
  logic [COLS-1:0] w_column;
  logic [ROWS-1:0] r_row;
  logic [COLS-1:0] r_column;
  logic            r_frame_start;

`ifdef SCAN_PWM_EN
  logic [3:0] r_bright_q;

  // Drive only the first (bright+1)/16 of the dwell window.
  assign w_pwm_ok = ((32'(r_dwell_cnt) * 32'd16) < ((32'(r_bright_q) + 32'd1) * 32'(DWELL)));
`else
  assign w_pwm_ok = 1'b1;
`endif

  assign w_idx_inc = r_idx + IW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_dwell_nxt  = r_dwell_cnt;
    w_blank_nxt  = r_blank_cnt;
    w_latch      = 1'b0;
    w_point_done = 1'b0;

    case (r_state)
      S_LATCH: begin
        w_latch     = 1'b1;
        w_idx_nxt   = '0;
        // Shadow is being loaded this cycle, so decide point 0 from the live inputs.
        w_state_nxt = (bus.skip_dark && !bus.ens[0]) ? S_SKIP : S_DWELL;
      end
      S_DWELL: begin
        if (r_dwell_cnt == DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (BLANK > 0) w_state_nxt = S_BLANK;
          else           w_point_done = 1'b1;
        end else begin
          w_dwell_nxt = r_dwell_cnt + DW'(1);
        end
      end
      S_BLANK: begin
        if (r_blank_cnt == BLANK_LAST) begin
          w_blank_nxt  = '0;
          w_point_done = 1'b1;
        end else begin
          w_blank_nxt = r_blank_cnt + BW'(1);
        end
      end
      S_SKIP: begin
        w_point_done = 1'b1;
      end
      default: begin
        w_state_nxt = S_LATCH;
      end
    endcase

    if (w_point_done) begin
      if (r_idx == LAST_IDX) begin
        w_state_nxt = S_LATCH;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt   = w_idx_inc;
        w_state_nxt = (r_skip_q && !r_shadow[w_idx_inc]) ? S_SKIP : S_DWELL;
      end
    end
  end

  assign w_on = (r_state == S_DWELL) && r_shadow[r_idx] && w_pwm_ok;

  scan_point_decode #(
    .ROWS (ROWS),
    .COLS (COLS),
    .IW   (IW)
  ) u_decode (
    .i_idx    (r_idx),
    .i_on     (w_on),
    .o_row    (w_row),
    .o_column (w_column)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state       <= S_LATCH;
      r_idx         <= '0;
      r_dwell_cnt   <= '0;
      r_blank_cnt   <= '0;
      r_shadow      <= '0;
      r_skip_q      <= 1'b0;
      r_row         <= '0;
      r_column      <= '0;
      r_frame_start <= 1'b0;
`ifdef SCAN_PWM_EN
      r_bright_q    <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_dwell_cnt   <= w_dwell_nxt;
      r_blank_cnt   <= w_blank_nxt;
      r_row         <= w_row;
      r_column      <= w_column;
      r_frame_start <= (r_state == S_LATCH);
      if (w_latch) begin
        r_shadow <= bus.ens;
        r_skip_q <= bus.skip_dark;
`ifdef SCAN_PWM_EN
        r_bright_q <= bus.bright;
`endif
      end
    end
  end

  assign bus.row         = r_row;
  assign bus.column      = r_column;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_scan_matrix.sv
// Bench for scan_matrix (2x3, DWELL=4, BLANK=2): frame-level reference model plus directed frames.
// Outputs are compared every cycle on the falling edge.
module tb_scan_matrix;

  localparam int R  = 2;
  localparam int C  = 3;
  localparam int NP = R * C;
  localparam int DW = 4;
  localparam int BL = 2;

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;

  scan_matrix_if #(.ROWS(R), .COLS(C)) bus ();

  scan_matrix #(
    .ROWS  (R),
    .COLS  (C),
    .DWELL (DW),
    .BLANK (BL)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the expected {frame_start,row,column} stream of a whole frame.
  logic [5:0]  exp_q[$];
  logic [NP-1:0] m_ens;
  logic        m_skip;
  logic        m_rst;
  bit          m_started = 0;

  task automatic build_frame(input logic [NP-1:0] e, input logic sk);
    logic [1:0] rb;
    logic [2:0] cb;
    exp_q.push_back(6'b100000);
    for (int p = 0; p < NP; p++) begin
      rb = 2'(1 << (p / C));
      cb = 3'(1 << (p % C));
      if (sk && !e[p]) begin
        exp_q.push_back(6'b0);
      end else begin
        for (int d = 0; d < DW; d++) exp_q.push_back(e[p] ? {1'b0, rb, cb} : 6'b0);
        for (int b = 0; b < BL; b++) exp_q.push_back(6'b0);
      end
    end
  endtask

  always @(posedge CLOCK_50) begin
    m_ens     = bus.ens;
    m_skip    = bus.skip_dark;
    m_rst     = RESET;
    m_started = 1;
  end

  always @(negedge CLOCK_50) begin
    logic [5:0] expv;
    if (m_started) begin
      if (m_rst) begin
        expv = 6'b0;
        exp_q.delete();
      end else begin
        if (exp_q.size() == 0) build_frame(m_ens, m_skip);
        expv = exp_q.pop_front();
      end
      chk("cycle", int'({bus.frame_start, bus.row, bus.column}), int'(expv));
    end
  end

  logic [4:0] snap [0:63];

  task automatic measure(output int per, output int lit);
    per = 0;
    lit = 0;
    for (int i = 0; i < 64; i++) snap[i] = 5'b0;
    snap[0] = {bus.row, bus.column};
    do begin
      @(negedge CLOCK_50);
      per++;
      if (per < 64) snap[per] = {bus.row, bus.column};
      if (bus.row != 0) lit++;
    end while (!bus.frame_start && per < 500);
    if (!bus.frame_start) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, lit, n;
    bus.ens       = 6'b111111;
    bus.skip_dark = 1'b0;
`ifdef SCAN_PWM_EN
    bus.bright    = 4'hF;
`endif
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_outputs", int'({bus.frame_start, bus.row, bus.column}), 0);

    RESET = 1'b0;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!bus.frame_start && n < 100);
    chk("first_fs_after_release", n, 1);

    // Mid-frame disable: this frame stays fully lit, the next is dark.
    bus.ens = 6'b0;
    measure(per, lit);
    chk("full_period", per, 37);
    chk("full_lit", lit, 24);
    chk("full_p0_first", int'(snap[1]), int'(5'b01_001));
    chk("full_p0_last", int'(snap[4]), int'(5'b01_001));
    chk("full_p0_blank", int'(snap[5]), 0);
    chk("full_p1", int'(snap[7]), int'(5'b01_010));
    chk("full_p3", int'(snap[19]), int'(5'b10_001));
    chk("full_p5", int'(snap[34]), int'(5'b10_100));
    chk("full_tail_blank", int'(snap[35]), 0);
    measure(per, lit);
    chk("dark_period", per, 37);
    chk("dark_lit", lit, 0);

    bus.ens       = 6'b000010;
    bus.skip_dark = 1'b1;
    measure(per, lit);
    chk("stale_period", per, 37);
    measure(per, lit);
    chk("single_period", per, 12);
    chk("single_lit", lit, 4);
    chk("single_skip0", int'(snap[1]), 0);
    chk("single_on_first", int'(snap[2]), int'(5'b01_010));
    chk("single_on_last", int'(snap[5]), int'(5'b01_010));
    chk("single_blank", int'(snap[6]), 0);

    bus.ens = 6'b0;
    measure(per, lit);
    chk("single_again", per, 12);
    measure(per, lit);
    chk("allskip_period", per, 7);
    chk("allskip_lit", lit, 0);

    bus.ens       = 6'b111111;
    bus.skip_dark = 1'b0;
    measure(per, lit);
    chk("allskip_again", per, 7);
    repeat (19) @(negedge CLOCK_50);
    chk("pre_reset_p3", int'({bus.row, bus.column}), int'(5'b10_001));
    RESET = 1'b1;
    @(negedge CLOCK_50);
    chk("midreset_zero", int'({bus.frame_start, bus.row, bus.column}), 0);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    chk("post_release_fs", int'({bus.frame_start, bus.row, bus.column}), int'(6'b100000));
    measure(per, lit);
    chk("post_reset_period", per, 37);
    chk("post_reset_lit", lit, 24);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/scan_matrix.md
SCAN_MATRIX -- requirements
Module: scan_matrix

Interface
REQ-001 SHALL have parameter ROWS, default 5, number of matrix rows (1..16).
REQ-002 SHALL have parameter COLS, default 7, number of matrix columns (1..16).
REQ-003 SHALL have parameter DWELL, default 16384, CLOCK_50 cycles a lit point is driven (>=1).
REQ-004 SHALL have parameter BLANK, default 64, all-off cycles after each dwell (>=0).
REQ-005 SHALL have port CLOCK_50, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ens, input, ROWS*COLS, point enables; bit r*COLS+c is row r, column c.
REQ-008 SHALL have port skip_dark, input, 1, when 1 dark points are skipped.
REQ-009 SHALL have port row, output, ROWS, one-hot row drive, registered.
REQ-010 SHALL have port column, output, COLS, one-hot column drive, registered.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse on every LATCH cycle.

Function
REQ-012 SHALL implement FSM states LATCH, DWELL, BLANK and SKIP.
REQ-013 LATCH SHALL last one cycle: shadow<=ens, skip_dark sampled into skip_q, idx<=0, frame_start=1.
REQ-014 Next state from LATCH or after a point SHALL be SKIP if skip_q=1 and shadow[idx]=0, else DWELL.
REQ-015 DWELL SHALL last exactly DWELL cycles; row[idx/COLS] and column[idx%COLS] SHALL be 1 only while shadow[idx]=1.
REQ-016 BLANK SHALL last exactly BLANK cycles with row=0 and column=0; BLANK=0 omits the state.
REQ-017 SKIP SHALL last one cycle with outputs zero.
REQ-018 After the point idx=ROWS*COLS-1 completes, the next state SHALL be LATCH; otherwise idx increments.
REQ-019 Frame length with skip_q=0 SHALL be 1+ROWS*COLS*(DWELL+BLANK) cycles; each dark point under skip_q=1 SHALL cost 1 cycle.
REQ-020 With all points dark and skip_q=1, frame SHALL be 1+ROWS*COLS cycles, outputs zero throughout.
REQ-021 Changes to ens or skip_dark mid-frame SHALL have no effect until the next LATCH.
REQ-022 At most one row bit and one column bit SHALL be 1 in any cycle.
REQ-023 Dwell counter SHALL be $clog2(DWELL+1) bits wide and SHALL not wrap within a state.

Reset
REQ-024 RESET=1 at a clock edge SHALL force state LATCH, idx=0, counters=0, shadow=0, skip_q=0, row=0, column=0, frame_start=0.
REQ-025 The first cycle after RESET deasserts SHALL be LATCH; a reset mid-frame SHALL abandon the frame with outputs zero in the next cycle.

Configuration
REQ-026 Macro SCAN_PWM_EN SHALL, when defined, add input bright[3:0], sampled at LATCH into bright_q.
REQ-027 With SCAN_PWM_EN, a lit point SHALL drive only while dwell_cnt*16 < (bright_q+1)*DWELL; dwell length SHALL be unchanged.
REQ-028 Without SCAN_PWM_EN, no bright port SHALL exist and lit points SHALL drive for the full DWELL.

Structure
REQ-029 Package scan_pkg SHALL hold the state enum and the idx-width function $clog2(ROWS*COLS).
REQ-030 Sub-module scan_point_decode SHALL map idx plus on-flag to one-hot row/column, combinationally.

Verification (ROWS=2, COLS=3, DWELL=4, BLANK=2 unless stated)
REQ-031 ens=6'b111111, skip_dark=0 -> frame_start every 37 cycles; each point lit 4 cycles then 2 off, order row0 col0..col2, row1.
REQ-032 ens=6'b000010, skip_dark=1 -> frame 12 cycles; row=2'b01, column=3'b010 for 4 cycles only.
REQ-033 ens=0, skip_dark=1 -> frame_start every 7 cycles, row/column always 0.
REQ-034 ens toggled to 0 mid-frame from 6'b111111 -> current frame completes fully lit; next frame dark.
REQ-035 RESET pulsed during DWELL of idx 3 -> outputs 0 next cycle; LATCH with frame_start=1 first cycle after release.
REQ-036 SCAN_PWM_EN, DWELL=16, bright=3, ens=6'b000001 -> point 0 on 4 of 16 dwell cycles, frame length unchanged.
